// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester ram arbiter.
// Contents: FSM state enum, requester id constants, default geometry.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

  localparam int DEF_MEM_BYTES = 1024;
  localparam int DEF_DATA_W    = 64;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the ram.
// slave  : arbiter side (takes requests, drives responses and ram controls)
// master : environment side (requesters plus the ram model)
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_rdata;
  logic              if_rsp_err;

  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_req_we;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_rdata;
  logic              d_rsp_err;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  modport slave (
    input  if_req_valid, if_req_addr,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    input  ram_data_out,
    output if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
    output ram_we, ram_addr, ram_data_in
  );

  modport master (
    output if_req_valid, if_req_addr,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    output ram_data_out,
    input  if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
    input  ram_we, ram_addr, ram_data_in
  );
endinterface

// File: rtl/mem_arb_picker.sv
// Combinational two-way grant between the fetch and data ports.
// Config macro MEM_ARB_RR_EN: round-robin with a last_grant register;
// otherwise fixed data-over-fetch priority and no state at all.
// Ports: clk/rst (round-robin build only), if_valid/d_valid requests
// (already qualified by the caller), grant_if/grant_d one-hot grants.
module mem_arb_picker
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic if_valid,
  input  logic d_valid,
  output logic grant_if,
  output logic grant_d
);

`ifdef MEM_ARB_RR_EN
  logic last_grant_q;
  logic last_grant_d;

  // On contention the port that did not win last time goes first; any
  // grant is an accepted request, so the history updates on every grant.
  always_comb begin
    grant_d      = d_valid & (~if_valid | (last_grant_q == GRANT_IF));
    grant_if     = if_valid & ~grant_d;
    last_grant_d = last_grant_q;
    if (grant_d)       last_grant_d = GRANT_D;
    else if (grant_if) last_grant_d = GRANT_IF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= GRANT_IF;
    else     last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    grant_d  = d_valid;
    grant_if = if_valid & ~d_valid;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing a single-port byte-addressed ram between the
// fetch port (read-only) and the data port (load/store). One access at a
// time: accept in IDLE, drive the ram in ISSUE, respond in RESP.
// Config macro MEM_ARB_RR_EN selects round-robin arbitration (see picker).
// Ports: clk, rst (async, active high), bus (mem_arbiter_if.slave) with
// both request/response channels and all ram controls.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  mem_arbiter_if.slave bus
);

  // Highest legal start address; plain unsigned compare so addresses near
  // the top of the space cannot wrap into range.
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 8);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              owner_q, owner_d;
  logic              err_q, err_d;

  logic              pick_if, pick_d;
  logic              idle;
  logic              ram_we_c;
  logic              if_rsp_c, d_rsp_c;
  logic [DATA_W-1:0] rsp_rdata;

  assign idle = (state_q == IDLE);

  mem_arb_picker u_picker (
`ifdef MEM_ARB_RR_EN
    .clk      (clk),
    .rst      (rst),
`endif
    .if_valid (bus.if_req_valid & idle),
    .d_valid  (bus.d_req_valid & idle),
    .grant_if (pick_if),
    .grant_d  (pick_d)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    owner_d  = owner_q;
    err_d    = err_q;
    ram_we_c = 1'b0;
    if_rsp_c = 1'b0;
    d_rsp_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          addr_d  = bus.d_req_addr;
          wdata_d = bus.d_req_wdata;
          we_d    = bus.d_req_we;
          owner_d = GRANT_D;
          err_d   = bus.d_req_addr > MAX_ADDR;
          state_d = ISSUE;
        end else if (pick_if) begin
          addr_d  = bus.if_req_addr;
          wdata_d = '0;
          we_d    = 1'b0;
          owner_d = GRANT_IF;
          err_d   = bus.if_req_addr > MAX_ADDR;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ram_we_c = we_q & ~err_q;
        state_d  = RESP;
      end
      RESP: begin
        if_rsp_c = (owner_q == GRANT_IF);
        d_rsp_c  = (owner_q == GRANT_D);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      owner_q <= GRANT_IF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // Stores and errored accesses return zero data; the read still happened
  // for an errored access but its result is discarded here.
  assign rsp_rdata = (we_q | err_q) ? '0 : bus.ram_data_out;

  assign bus.if_req_ready = pick_if;
  assign bus.d_req_ready  = pick_d;

  assign bus.if_rsp_valid = if_rsp_c;
  assign bus.if_rsp_rdata = if_rsp_c ? rsp_rdata : '0;
  assign bus.if_rsp_err   = if_rsp_c & err_q;
  assign bus.d_rsp_valid  = d_rsp_c;
  assign bus.d_rsp_rdata  = d_rsp_c ? rsp_rdata : '0;
  assign bus.d_rsp_err    = d_rsp_c & err_q;

  assign bus.ram_we       = ram_we_c;
  assign bus.ram_addr     = addr_q;
  assign bus.ram_data_in  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A little-endian byte-array ram model
// sits on the ram side; a transaction-level reference (byte array + phase
// counter + arbitration rule) predicts every ready, ram write and response.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int          MB   = 1024;
  localparam logic [63:0] MAXA = 64'd1016;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   we_cnt   = 0;

  mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ram emulation (1-cycle registered read) --------------
  logic [7:0] ram [MB];

  function automatic logic [63:0] ram_rd(input logic [63:0] a);
    logic [63:0] v;
    v = '0;
    if (a <= MAXA)
      for (int i = 0; i < 8; i++) v[8*i +: 8] = ram[int'(a[9:0]) + i];
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MB; i++) ram[i] <= 8'h00;
      bus.ram_data_out <= '0;
    end else begin
      if (bus.ram_we) begin
        we_cnt <= we_cnt + 1;
        if (bus.ram_addr <= MAXA)
          for (int i = 0; i < 8; i++)
            ram[int'(bus.ram_addr[9:0]) + i] <= bus.ram_data_in[8*i +: 8];
      end
      bus.ram_data_out <= ram_rd(bus.ram_addr);
    end
  end

  // ---------------- reference model --------------------------------------
  logic [7:0]  ref_mem [MB];
  int          phase;      // 0 free, 1 access in flight, 2 response due
  logic        m_port_d;   // 1 = data port owns the access
  logic        m_we, m_err, m_last_d;
  logic [63:0] m_addr, m_wdata, m_rdata;

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[int'(a[9:0]) + i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check at negedge+1, advance model at posedge.
  task automatic step(input logic iv, input logic [63:0] ia, input logic dv,
                      input logic dwe, input logic [63:0] da, input logic [63:0] dwd);
    logic take_d, take_if;
    @(negedge clk);
    bus.if_req_valid = iv;
    bus.if_req_addr  = ia;
    bus.d_req_valid  = dv;
    bus.d_req_we     = dwe;
    bus.d_req_addr   = da;
    bus.d_req_wdata  = dwd;
    #1;
    take_d  = 1'b0;
    take_if = 1'b0;
    if (phase == 0) begin
      take_d  = dv && (!iv || !RR || !m_last_d);
      take_if = iv && !take_d;
    end
    check("if_req_ready", bus.if_req_ready, take_if);
    check("d_req_ready", bus.d_req_ready, take_d);
    check("ram_we", bus.ram_we, phase == 1 && m_we && !m_err);
    if (phase == 1) begin
      check("ram_addr", bus.ram_addr, m_addr);
      if (m_we) check("ram_data_in", bus.ram_data_in, m_wdata);
    end
    check("if_rsp_valid", bus.if_rsp_valid, phase == 2 && !m_port_d);
    check("d_rsp_valid", bus.d_rsp_valid, phase == 2 && m_port_d);
    if (phase == 2) begin
      if (m_port_d) begin
        check("d_rsp_rdata", bus.d_rsp_rdata, m_rdata);
        check("d_rsp_err", bus.d_rsp_err, m_err);
      end else begin
        check("if_rsp_rdata", bus.if_rsp_rdata, m_rdata);
        check("if_rsp_err", bus.if_rsp_err, m_err);
      end
    end
    @(posedge clk);
    if (phase == 2) phase = 0;
    else if (phase == 1) phase = 2;
    else if (take_d || take_if) begin
      m_port_d = take_d;
      m_addr   = take_d ? da : ia;
      m_we     = take_d ? dwe : 1'b0;
      m_wdata  = dwd;
      m_err    = m_addr > MAXA;
      m_rdata  = (m_we || m_err) ? 64'h0 : ref_read(m_addr);
      if (m_we && !m_err)
        for (int i = 0; i < 8; i++) ref_mem[int'(m_addr[9:0]) + i] = m_wdata[8*i +: 8];
      m_last_d = take_d;
      phase    = 1;
    end
  endtask

  task automatic idle_step();
    step(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
  endtask

  task automatic d_op(input logic we, input logic [63:0] a, input logic [63:0] wd);
    step(1'b0, 64'h0, 1'b1, we, a, wd);
    idle_step();
    idle_step();
  endtask

  task automatic if_op(input logic [63:0] a);
    step(1'b1, a, 1'b0, 1'b0, 64'h0, 64'h0);
    idle_step();
    idle_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.if_req_valid = 1'b0;
    bus.d_req_valid  = 1'b0;
    bus.d_req_we     = 1'b0;
    #1;
    check("rst_if_ready", bus.if_req_ready, 1'b0);
    check("rst_d_ready", bus.d_req_ready, 1'b0);
    check("rst_if_rsp_valid", bus.if_rsp_valid, 1'b0);
    check("rst_d_rsp_valid", bus.d_rsp_valid, 1'b0);
    check("rst_ram_we", bus.ram_we, 1'b0);
    check("rst_ram_addr", bus.ram_addr, 64'h0);
    check("rst_ram_data_in", bus.ram_data_in, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    phase    = 0;
    m_last_d = 1'b0;
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;
  endtask

  function automatic logic [63:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return {1'b1, $urandom(), 31'($urandom())};
    if (r == 1) return 64'd1017 + 64'($urandom_range(0, 6));
    if (r == 2) return 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
    return 64'($urandom_range(0, 1016));
  endfunction

  int          w0;
  int          if_seen;
  logic [63:0] ra;

  initial begin
    rst = 1'b1;
    bus.if_req_valid = 1'b0;
    bus.if_req_addr  = '0;
    bus.d_req_valid  = 1'b0;
    bus.d_req_we     = 1'b0;
    bus.d_req_addr   = '0;
    bus.d_req_wdata  = '0;
    phase = 0;
    m_last_d = 1'b0;
    m_port_d = 1'b0;
    {m_we, m_err} = '0;
    {m_addr, m_wdata, m_rdata} = '0;

    do_reset();

    // store then load at 0x10; exactly one write-enable cycle for the store
    w0 = we_cnt;
    d_op(1'b1, 64'h10, 64'h1122_3344_5566_7788);
    check("store_we_cycles", 64'(we_cnt - w0), 64'd1);
    d_op(1'b0, 64'h10, 64'h0);
    check("load_no_we", 64'(we_cnt - w0), 64'd1);

    // out-of-range store at 1017 must not write; 1016 keeps its contents
    d_op(1'b1, 64'd1016, 64'hCAFE_F00D_1234_5678);
    w0 = we_cnt;
    d_op(1'b1, 64'd1017, 64'hDEAD_BEEF_DEAD_BEEF);
    check("err_store_no_we", 64'(we_cnt - w0), 64'd0);
    d_op(1'b0, 64'd1016, 64'h0);
    d_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h5555);
    if_op(64'hFFFF_FFFF_FFFF_FFF9);
    check("wrap_err_no_we", 64'(we_cnt - w0), 64'd0);

    // unaligned fetch across two stored words
    d_op(1'b1, 64'h0, 64'hAABB_CCDD_EEFF_0011);
    d_op(1'b1, 64'h8, 64'h0);
    if_op(64'h3);

    // simultaneous requests: data first by default, then fetch
    step(1'b1, 64'h10, 1'b1, 1'b0, 64'h0, 64'h0);
    for (int k = 0; k < 5; k++) step(1'b1, 64'h10, 1'b0, 1'b0, 64'h0, 64'h0);
    idle_step();
    idle_step();

    // back-to-back contention from a fresh reset (alternates under round-robin)
    do_reset();
    for (int k = 0; k < 12; k++) step(1'b1, 64'(8 * k), 1'b1, 1'b0, 64'(8 * k + 4), 64'h0);
    idle_step();
    idle_step();

    // fetch held, data pulsed every cycle
    if_seen = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 64'h20, 1'b1, 1'b0, 64'h28, 64'h0);
      if (bus.if_rsp_valid) if_seen = 1;
    end
    for (int k = 0; k < 12; k++) step(1'b1, 64'h20, 1'b1, 1'b0, 64'h28, 64'h0);
    check("starve_fetch_rsp", 64'(if_seen), 64'(RR));
    idle_step();
    idle_step();
    idle_step();

    // reset in ISSUE of a load; response must be dropped
    d_op(1'b1, 64'h40, 64'h0123_4567_89AB_CDEF);
    step(1'b0, 64'h0, 1'b1, 1'b0, 64'h40, 64'h0);
    do_reset();
    idle_step();
    idle_step();
    d_op(1'b1, 64'h48, 64'h0F0F_0F0F_F0F0_F0F0);
    d_op(1'b0, 64'h48, 64'h0);

    // randomized traffic; inputs scrambled freely while an access is in flight
    for (int k = 0; k < 400; k++) begin
      ra = rand_addr();
      step(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ra, {$urandom(), $urandom()});
    end
    idle_step();
    idle_step();
    idle_step();
    for (int k = 0; k < 16; k++) d_op(1'b0, 64'(8 * $urandom_range(0, 127)), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
